fp_class_pipe: RTL

FP_CLASS_PIPE -- requirements
Module: fp_class_pipe

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_class_decode.sv | 32 +++
 rtl/fp_class_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point class codes
// and small helpers used by FP datapath blocks.
package fp_pkg;

   typedef logic [2:0] fp_cls_t;

   localparam fp_cls_t CLS_ZERO    = 3'b000;
   localparam fp_cls_t CLS_SUBNORM = 3'b001;
   localparam fp_cls_t CLS_NORMAL  = 3'b011;
   localparam fp_cls_t CLS_INF     = 3'b100;
   localparam fp_cls_t CLS_QNAN    = 3'b110;
   localparam fp_cls_t CLS_SNAN    = 3'b111;

   // sticky flag bit positions: {nan, inf, sub, zero}
   localparam int FLG_ZERO = 0;
   localparam int FLG_SUB  = 1;
   localparam int FLG_INF  = 2;
   localparam int FLG_NAN  = 3;

   function automatic logic [3:0] cls_flag(input fp_cls_t c);
      logic [3:0] f;
      f = 4'b0000;
      case (c)
         CLS_ZERO:    f[FLG_ZERO] = 1'b1;
         CLS_SUBNORM: f[FLG_SUB]  = 1'b1;
         CLS_INF:     f[FLG_INF]  = 1'b1;
         CLS_QNAN:    f[FLG_NAN]  = 1'b1;
         CLS_SNAN:    f[FLG_NAN]  = 1'b1;
         default:     f = 4'b0000;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/fp_class_decode.sv
// fp_class_decode: pre-decoded exponent/mantissa
// field flags to a class code. Purely combinational.
module fp_class_decode
   import fp_pkg::*;
(
   input  logic    exp_zero,
   input  logic    exp_ones,
   input  logic    man_zero,
   input  logic    man_msb,
   output fp_cls_t cls
);

   // one-hot field patterns; anything else is a normal number
   always_comb begin
      cls = CLS_NORMAL;
      unique case (1'b1)
         (exp_zero && man_zero):
            cls = CLS_ZERO;
         (exp_zero && !man_zero):
            cls = CLS_SUBNORM;
         (exp_ones && man_zero):
            cls = CLS_INF;
         (exp_ones && !man_zero && man_msb):
            cls = CLS_QNAN;
         (exp_ones && !man_zero && !man_msb):
            cls = CLS_SNAN;
         default:
            cls = CLS_NORMAL;
      endcase
   end

endmodule

// File: rtl/fp_class_pipe.sv
// fp_class_pipe: two-stage valid/ready classifier
// with sticky class flags and a saturating NaN counter.
module fp_class_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int CNT_W = 16,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [2:0]       out_class,
   output logic             out_sign,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] nan_cnt,
   input  logic             flags_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             s1_valid_q, s1_valid_d;
   logic [W-1:0]     s1_data_q, s1_data_d;
   logic             s1_ez_q, s1_ez_d;
   logic             s1_eo_q, s1_eo_d;
   logic             s1_mz_q, s1_mz_d;
   logic             s1_mm_q, s1_mm_d;

   logic             s2_valid_q, s2_valid_d;
   logic [W-1:0]     s2_data_q, s2_data_d;
   fp_cls_t          s2_cls_q, s2_cls_d;
   logic             s2_sign_q, s2_sign_d;

   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;

   logic             s2_ready, s1_ready;
   logic             s1_load, s2_load, s2_adv;
   fp_cls_t          dec_cls;

   logic [EXP_W-1:0] in_exp;
   logic [MAN_W-1:0] in_man;

   assign in_exp = in_data[MAN_W +: EXP_W];
   assign in_man = in_data[MAN_W-1:0];

   fp_class_decode u_dec (
      .exp_zero (s1_ez_q),
      .exp_ones (s1_eo_q),
      .man_zero (s1_mz_q),
      .man_msb  (s1_mm_q),
      .cls      (dec_cls)
   );

   // handshake: each stage frees up when empty or draining
   always_comb begin
      s2_adv   = s2_valid_q && out_ready;
      s2_ready = !s2_valid_q || out_ready;
      s1_ready = !s1_valid_q || s2_ready;
      s1_load  = in_valid && s1_ready;
      s2_load  = s1_valid_q && s2_ready;
   end

   assign in_ready  = s1_ready;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_class = s2_cls_q;
   assign out_sign  = s2_sign_q;
   assign flags     = flags_q;
   assign nan_cnt   = nan_cnt_q;

   // next-state for valids and stage payloads
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_ez_d    = s1_ez_q;
      s1_eo_d    = s1_eo_q;
      s1_mz_d    = s1_mz_q;
      s1_mm_d    = s1_mm_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_cls_d   = s2_cls_q;
      s2_sign_d  = s2_sign_q;
      if (s1_load) begin
         s1_valid_d = 1'b1;
         s1_data_d  = in_data;
         s1_ez_d    = (in_exp == '0);
         s1_eo_d    = (in_exp == '1);
         s1_mz_d    = (in_man == '0);
         s1_mm_d    = in_man[MAN_W-1];
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
      if (s2_load) begin
         s2_valid_d = 1'b1;
         s2_data_d  = s1_data_q;
         s2_cls_d   = dec_cls;
         s2_sign_d  = s1_data_q[W-1];
      end else if (s2_adv) begin
         s2_valid_d = 1'b0;
      end
   end

   // sticky flags and NaN count, recorded on delivery
   always_comb begin
      logic [3:0]       f_base;
      logic [CNT_W-1:0] c_base;
      logic [3:0]       f_new;
      f_base = flags_clr ? 4'b0000 : flags_q;
      c_base = flags_clr ? '0 : nan_cnt_q;
      f_new  = s2_adv ? cls_flag(s2_cls_q) : 4'b0000;
      flags_d   = f_base | f_new;
      nan_cnt_d = c_base;
      if (f_new[FLG_NAN] && (c_base != CNT_MAX)) begin
         nan_cnt_d = c_base + CNT_W'(1);
      end
   end

   // control state: valids, flags, counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         flags_q    <= 4'b0000;
         nan_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         flags_q    <= flags_d;
         nan_cnt_q  <= nan_cnt_d;
      end
   end

   // payload registers carry no reset
   always_ff @(posedge clk) begin
      s1_data_q <= s1_data_d;
      s1_ez_q   <= s1_ez_d;
      s1_eo_q   <= s1_eo_d;
      s1_mz_q   <= s1_mz_d;
      s1_mm_q   <= s1_mm_d;
      s2_data_q <= s2_data_d;
      s2_cls_q  <= s2_cls_d;
      s2_sign_q <= s2_sign_d;
   end

endmodule
